// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage
// Instruction-fetch front end: owns the fetch PC, issues word fetches over a
// req/ack handshake and buffers {pc, instr} pairs in a DEPTH-entry FIFO that
// feeds decode through a valid/ready handshake. A branch redirect flushes the
// queue and any in-flight fetch, then inserts a one-cycle bubble.
// Optional feature macro: FETCH_BYPASS_EN (empty-queue fetch goes straight to
// decode in the same cycle, skipping the queue).
module fetch_queue_stage #(
  parameter int              PC_W     = 9,
  parameter int              INS_W    = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic                       imem_ack,
  input  logic [INS_W-1:0]           imem_rdata,
  input  logic                       redir_valid,
  input  logic [PC_W-1:0]            redir_pc,
  output logic                       if_valid,
  output logic [PC_W-1:0]            if_pc,
  output logic [INS_W-1:0]           if_instr,
  input  logic                       id_ready,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  logic [1:0]       r_state;
  logic [PC_W-1:0]  r_fpc;
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    r_rdPtr;
  logic [AW-1:0]    r_wrPtr;
  logic [PC_W-1:0]  r_memPc  [DEPTH];
  logic [INS_W-1:0] r_memIns [DEPTH];

  logic w_accept;
  logic w_qValid;
  logic w_deq;
  logic w_enq;
  logic w_bypass;
  logic w_bypassTake;

  assign w_accept = (r_state == S_FETCH) && imem_ack;
  assign w_qValid = (r_count != '0);
  // A redirect flushes decode, so a same-cycle handshake does not count.
  assign w_deq    = w_qValid && id_ready && !redir_valid;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = !w_qValid && w_accept && !redir_valid;
`else
  assign w_bypass = 1'b0;
`endif
  assign w_bypassTake = w_bypass && id_ready;

  // Acked data during a redirect is dropped; bypassed-and-consumed data never enters the queue.
  assign w_enq = w_accept && !redir_valid && !w_bypassTake;

  assign imem_req  = (r_state == S_FETCH);
  assign imem_addr = r_fpc;
  assign q_count   = r_count;
  assign if_valid  = w_qValid || w_bypass;

  // Head of queue toward decode; forced to zero when nothing is valid.
  always_comb begin
    if_pc    = '0;
    if_instr = '0;
    if (w_qValid) begin
      if_pc    = r_memPc[r_rdPtr];
      if_instr = r_memIns[r_rdPtr];
    end else if (w_bypass) begin
      if_pc    = r_fpc;
      if_instr = imem_rdata;
    end
  end

  // Control state: fetch PC, FSM, occupancy and pointers (reset beats redirect beats everything else).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_REDIR;
      r_fpc   <= RESET_PC;
      r_count <= '0;
      r_rdPtr <= '0;
      r_wrPtr <= '0;
    end else if (redir_valid) begin
      r_state <= S_REDIR;
      r_fpc   <= {redir_pc[PC_W-1:2], 2'b00};
      r_count <= '0;
      r_rdPtr <= '0;
      r_wrPtr <= '0;
    end else begin
      if (w_accept) begin
        r_fpc <= r_fpc + PC_W'(4);
      end
      if (w_enq) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_deq) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
      case (r_state)
        S_FETCH: begin
          if (w_enq && !w_deq && (r_count == CW'(DEPTH - 1))) begin
            r_state <= S_FULL;
          end
        end
        S_FULL: begin
          if (w_deq) begin
            r_state <= S_FETCH;
          end
        end
        S_REDIR: r_state <= S_FETCH;
        default: r_state <= S_REDIR;
      endcase
    end
  end

  // Queue storage; contents are only meaningful between the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_memPc[r_wrPtr]  <= r_fpc;
      r_memIns[r_wrPtr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage
// Directed plus randomised stimulus for fetch_queue_stage. A scoreboard queue
// receives {pc, instr} whenever an accepted fetch is driven and is popped when
// decode takes the head. Honours FETCH_BYPASS_EN when defined.
module tb_fetch_queue_stage;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;
  localparam int DEPTH = 4;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  localparam logic [1:0] M_FETCH = 2'd0;
  localparam logic [1:0] M_FULL  = 2'd1;
  localparam logic [1:0] M_REDIR = 2'd2;

  logic clk = 1'b0;
  logic reset;
  logic imem_req;
  logic [PC_W-1:0] imem_addr;
  logic imem_ack;
  logic [INS_W-1:0] imem_rdata;
  logic redir_valid;
  logic [PC_W-1:0] redir_pc;
  logic if_valid;
  logic [PC_W-1:0] if_pc;
  logic [INS_W-1:0] if_instr;
  logic id_ready;
  logic [$clog2(DEPTH):0] q_count;

  int passCount = 0;
  int totalCount = 0;

  logic [PC_W+INS_W-1:0] sb[$];
  logic [PC_W-1:0] mFpc;
  logic [1:0] mState;
  bit mKnown = 0;

  fetch_queue_stage #(
    .PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .id_ready(id_ready), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit bypassNow();
    bit b;
    b = 1'b0;
`ifdef FETCH_BYPASS_EN
    b = (sb.size() == 0) && (mState == M_FETCH) && imem_ack && !redir_valid;
`endif
    return b;
  endfunction

  task automatic checkOutput();
    logic [PC_W-1:0] ePc;
    logic [INS_W-1:0] eIns;
    bit byp;
    byp = bypassNow();
    ePc = '0;
    eIns = '0;
    if (sb.size() != 0) begin
      ePc = sb[0][PC_W+INS_W-1:INS_W];
      eIns = sb[0][INS_W-1:0];
    end else if (byp) begin
      ePc = mFpc;
      eIns = imem_rdata;
    end
    check("imem_req", imem_req, (mState == M_FETCH));
    check("imem_addr", imem_addr, mFpc);
    check("q_count", q_count, sb.size());
    check("if_valid", if_valid, (sb.size() != 0) || byp);
    check("if_pc", if_pc, ePc);
    check("if_instr", if_instr, eIns);
  endtask

  task automatic commitModel();
    bit acc, take, deq;
    int oldCnt;
    if (reset) begin
      sb.delete();
      mFpc = RESET_PC;
      mState = M_REDIR;
    end else if (redir_valid) begin
      sb.delete();
      mFpc = {redir_pc[PC_W-1:2], 2'b00};
      mState = M_REDIR;
    end else begin
      acc = (mState == M_FETCH) && imem_ack;
      take = bypassNow() && id_ready;
      oldCnt = sb.size();
      deq = (oldCnt > 0) && id_ready;
      if (deq) void'(sb.pop_front());
      if (acc && !take) sb.push_back({mFpc, imem_rdata});
      if (acc) mFpc = mFpc + 9'd4;
      case (mState)
        M_FETCH: if (acc && !take && !deq && oldCnt == DEPTH - 1) mState = M_FULL;
        M_FULL:  if (deq) mState = M_FETCH;
        default: mState = M_FETCH;
      endcase
    end
  endtask

  task automatic applyStimulus(input bit ack, input logic [INS_W-1:0] rd, input bit rdy,
                               input bit rdv, input logic [PC_W-1:0] rpc, input bit rst);
    @(negedge clk);
    imem_ack = ack;
    imem_rdata = rd;
    id_ready = rdy;
    redir_valid = rdv;
    redir_pc = rpc;
    reset = rst;
    #1;
    if (mKnown) checkOutput();
    commitModel();
    if (rst) mKnown = 1;
  endtask

  initial begin
    reset = 1; imem_ack = 0; imem_rdata = '0; id_ready = 0; redir_valid = 0; redir_pc = '0;
    mFpc = RESET_PC; mState = M_REDIR;

    // Reset and the post-reset bubble.
    repeat (3) applyStimulus(0, 32'h0, 0, 0, 9'h0, 1);
    applyStimulus(1, 32'hA000_0000, 1, 0, 9'h0, 0);

    // Streaming with ack and ready tied high.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 32'hA000_0000 + 32'(i), 1, 0, 9'h0, 0);
      check("stream_addr", imem_addr, 64'(i * 4));
      check("stream_req", imem_req, 1);
`ifdef FETCH_BYPASS_EN
      check("bypass_count", q_count, 0);
      check("bypass_valid", if_valid, 1);
      check("bypass_pc", if_pc, 64'(i * 4));
`endif
    end

    // Decode stall until the queue fills.
    for (int i = 0; i < 6; i++) applyStimulus(1, 32'hB000_0000 + 32'(i), 0, 0, 9'h0, 0);
    applyStimulus(1, 32'hDEAD_0001, 1, 0, 9'h0, 0);
    check("full_req", imem_req, 0);
    check("full_count", q_count, DEPTH);
    applyStimulus(0, 32'hDEAD_0002, 0, 0, 9'h0, 0);
    check("refetch_req", imem_req, 1);
    check("refetch_count", q_count, DEPTH - 1);

    // Redirect while acking with three entries queued.
    applyStimulus(1, 32'hDEAD_0003, 0, 1, 9'h040, 0);
    applyStimulus(0, 32'h0, 1, 0, 9'h0, 0);
    check("redir_valid_drop", if_valid, 0);
    check("redir_bubble_req", imem_req, 0);
    applyStimulus(0, 32'h0, 1, 0, 9'h0, 0);
    check("redir_req", imem_req, 1);
    check("redir_addr", imem_addr, 9'h040);

    // Wrap from the top word; low bits of the target are ignored.
    applyStimulus(0, 32'h0, 0, 1, 9'h1FE, 0);
    applyStimulus(0, 32'h0, 0, 0, 9'h0, 0);
    applyStimulus(1, 32'hC0DE_01FC, 0, 0, 9'h0, 0);
    check("wrap_addr_top", imem_addr, 9'h1FC);
    applyStimulus(0, 32'h0, 0, 0, 9'h0, 0);
    check("wrap_addr_zero", imem_addr, 9'h000);
`ifndef FETCH_BYPASS_EN
    check("wrap_head_pc", if_pc, 9'h1FC);
`endif

    // Ack held low, reset lands in the second cycle.
    applyStimulus(0, 32'h0, 0, 0, 9'h0, 0);
    check("hold_addr", imem_addr, 9'h000);
    applyStimulus(0, 32'h0, 0, 0, 9'h0, 1);
    check("hold_addr2", imem_addr, 9'h000);
    applyStimulus(0, 32'h0, 0, 0, 9'h0, 0);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", if_valid, 0);
    check("rst_pc", if_pc, 0);
    check("rst_instr", if_instr, 0);
    check("rst_count", q_count, 0);

    // Random traffic with occasional redirects.
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 15) == 0), 9'($urandom), 0);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
